// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache access sequencer.
// The optional access watchdog in the top is enabled with ACCESS_TIMEOUT_EN.
package cache_pkg;

    localparam int CACHE_ADDR_W   = 15;
    localparam int DEF_START_ADDR = 1024;
    localparam int DEF_END_ADDR   = 9215;

    localparam logic HIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SAMPLE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/cache_access_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_access_sequencer.sv
// Sweeps an address range through the cache controller handshake and counts accesses/hits.
// Define ACCESS_TIMEOUT_EN to add a WAIT-state watchdog and the timeout output.
module cache_access_sequencer
    import cache_pkg::*;
#(
    parameter int ADDR_W         = CACHE_ADDR_W,
    parameter int START_ADDR     = DEF_START_ADDR,
    parameter int END_ADDR       = DEF_END_ADDR,
    parameter int STRIDE         = 1,
    parameter int CNT_W          = 14,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              ready,
    input  logic              hm_bar,
    output logic              start,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count
`ifdef ACCESS_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    if (STRIDE < 1) begin : g_badStride
        $error("STRIDE must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [ADDR_W-1:0] START_A    = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   END_EXT    = (ADDR_W+1)'(END_ADDR);
    localparam logic [ADDR_W:0]   STRIDE_EXT = (ADDR_W+1)'(STRIDE);

    seq_state_e        r_state;
    seq_state_e        w_nextState;
    logic [ADDR_W-1:0] r_address;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   w_nextAddr;
    logic              w_restart;
    logic              w_sample;
    logic              w_advance;

`ifdef ACCESS_TIMEOUT_EN
    localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    logic [WCNT_W-1:0] r_waitCnt;
    logic              r_timeout;
    logic              w_timeoutHit;
`endif

    // One extra bit so an overshooting step is seen as "past the end" instead of wrapping.
    assign w_nextAddr = {1'b0, r_address} + STRIDE_EXT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_restart   = 1'b0;
        w_sample    = 1'b0;
        w_advance   = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
        w_timeoutHit = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    w_restart   = 1'b1;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    w_nextState = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_sample    = 1'b1;
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready) begin
                    if (w_nextAddr > END_EXT) begin
                        w_nextState = ST_DONE;
                    end else begin
                        w_advance   = 1'b1;
                        w_nextState = ST_ISSUE;
                    end
                end
`ifdef ACCESS_TIMEOUT_EN
                else if (r_waitCnt == WCNT_LAST) begin
                    w_timeoutHit = 1'b1;
                    w_nextState  = ST_DONE;
                end
`endif
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Address only moves on a restart or a completed transaction, so it is stable mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_address <= START_A;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_restart) begin
                r_address <= START_A;
            end else if (w_advance) begin
                r_address <= w_nextAddr[ADDR_W-1:0];
            end
            r_busy <= (w_nextState == ST_ISSUE) || (w_nextState == ST_SAMPLE) ||
                      (w_nextState == ST_WAIT);
            r_done <= (w_nextState == ST_DONE);
        end
    end

`ifdef ACCESS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_WAIT) && !ready) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end else begin
                r_waitCnt <= '0;
            end
            if (w_restart) begin
                r_timeout <= 1'b0;
            end else if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`endif

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_accessCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_restart),
        .i_en    (w_sample),
        .o_count (access_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_hitCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_restart),
        .i_en    (w_sample && (hm_bar == HIT)),
        .o_count (hit_count)
    );

    assign start   = (r_state == ST_ISSUE);
    assign address = r_address;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Directed bench: four sequencer configurations share one behavioural cache-controller model.
module tb_cache_access_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic ready;
    logic hm_bar;
    logic goA, goB, goC, goD;

    logic        startA, busyA, doneA;
    logic [14:0] addrA;
    logic [13:0] accA, hitA;
    logic        startB, busyB, doneB;
    logic [14:0] addrB;
    logic [13:0] accB, hitB;
    logic        startC, busyC, doneC;
    logic [14:0] addrC;
    logic [13:0] accC, hitC;
    logic        startD, busyD, doneD;
    logic [3:0]  addrD;
    logic [1:0]  accD, hitD;
`ifdef ACCESS_TIMEOUT_EN
    logic timeoutA, timeoutB, timeoutC, timeoutD;
`endif

    int          passCount  = 0;
    int          checkCount = 0;
    int          failCount  = 0;
    int          remaining  = 0;
    bit          stuck      = 1'b0;
    bit          missMode   = 1'b0;
    int          sel        = 0;
    int          expStride  = 1;
    int          used;
    logic [14:0] expAddr    = '0;
    logic [14:0] holdAddr   = '0;

    logic        selStart, selDone;
    logic [14:0] selAddr;

    always #5 clk = ~clk;

    cache_access_sequencer #(.START_ADDR(1024), .END_ADDR(1031)) u_dutA (
        .clk(clk), .rst_n(rst_n), .go(goA), .ready(ready), .hm_bar(hm_bar),
        .start(startA), .address(addrA), .busy(busyA), .done(doneA),
        .access_count(accA), .hit_count(hitA)
`ifdef ACCESS_TIMEOUT_EN
        , .timeout(timeoutA)
`endif
    );

    cache_access_sequencer #(.START_ADDR(1024), .END_ADDR(1039)) u_dutB (
        .clk(clk), .rst_n(rst_n), .go(goB), .ready(ready), .hm_bar(hm_bar),
        .start(startB), .address(addrB), .busy(busyB), .done(doneB),
        .access_count(accB), .hit_count(hitB)
`ifdef ACCESS_TIMEOUT_EN
        , .timeout(timeoutB)
`endif
    );

    cache_access_sequencer #(.START_ADDR(0), .END_ADDR(7), .STRIDE(3)) u_dutC (
        .clk(clk), .rst_n(rst_n), .go(goC), .ready(ready), .hm_bar(hm_bar),
        .start(startC), .address(addrC), .busy(busyC), .done(doneC),
        .access_count(accC), .hit_count(hitC)
`ifdef ACCESS_TIMEOUT_EN
        , .timeout(timeoutC)
`endif
    );

    cache_access_sequencer #(.ADDR_W(4), .START_ADDR(9), .END_ADDR(15), .STRIDE(2), .CNT_W(2)) u_dutD (
        .clk(clk), .rst_n(rst_n), .go(goD), .ready(ready), .hm_bar(hm_bar),
        .start(startD), .address(addrD), .busy(busyD), .done(doneD),
        .access_count(accD), .hit_count(hitD)
`ifdef ACCESS_TIMEOUT_EN
        , .timeout(timeoutD)
`endif
    );

    // The cache model follows whichever sequencer is under test.
    always_comb begin
        selStart = startA;
        selAddr  = addrA;
        selDone  = doneA;
        case (sel)
            1: begin selStart = startB; selAddr = addrB; selDone = doneB; end
            2: begin selStart = startC; selAddr = addrC; selDone = doneC; end
            3: begin selStart = startD; selAddr = {11'b0, addrD}; selDone = doneD; end
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock of the controller: accepts start when ready, then stays busy for 2 (hit) or 3 (miss) cycles.
    task automatic applyStimulus();
        logic        accept;
        logic [14:0] acceptAddr;
        if (remaining > 0) checkOutput("addrHold", 32'(selAddr), 32'(holdAddr));
        accept     = selStart && ready;
        acceptAddr = selAddr;
        @(posedge clk);
        #1;
        if (accept) begin
            checkOutput("issueAddr", 32'(acceptAddr), 32'(expAddr));
            expAddr   = expAddr + 15'(expStride);
            holdAddr  = acceptAddr;
            hm_bar    = !(missMode && (acceptAddr[1:0] == 2'b00));
            remaining = hm_bar ? 2 : 3;
            ready     = 1'b0;
        end else if ((remaining > 0) && !stuck) begin
            remaining--;
            ready = (remaining == 0);
        end
    endtask

    task automatic pulseGo();
        goA = (sel == 0);
        goB = (sel == 1);
        goC = (sel == 2);
        goD = (sel == 3);
        applyStimulus();
        goA = 1'b0;
        goB = 1'b0;
        goC = 1'b0;
        goD = 1'b0;
    endtask

    task automatic runSweep(input int budget, output int cyclesUsed);
        cyclesUsed = 0;
        while (!selDone && (cyclesUsed < budget)) begin
            applyStimulus();
            cyclesUsed++;
        end
        checkOutput("sweepDone", 32'(selDone), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        ready  = 1'b1;
        hm_bar = 1'b1;
        goA = 1'b0; goB = 1'b0; goC = 1'b0; goD = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstStart", 32'(startA), 32'd0);
        checkOutput("rstBusy",  32'(busyA),  32'd0);
        checkOutput("rstDone",  32'(doneA),  32'd0);
        checkOutput("rstAddr",  32'(addrA),  32'd1024);
        checkOutput("rstAcc",   32'(accA),   32'd0);
        checkOutput("rstHit",   32'(hitA),   32'd0);
        checkOutput("rstAddrD", 32'(addrD),  32'd9);
        rst_n = 1'b1;

        // All-hit sweep 1024..1031: 8 accesses at 4 cycles each.
        $display("[TB] all-hit sweep");
        sel = 0; expAddr = 15'd1024; expStride = 1;
        pulseGo();
        checkOutput("goBusy",  32'(busyA),  32'd1);
        checkOutput("goStart", 32'(startA), 32'd1);
        checkOutput("goAddr",  32'(addrA),  32'd1024);
        runSweep(100, used);
        checkOutput("hitCycles", 32'(used),  32'd32);
        checkOutput("hitAcc",    32'(accA),  32'd8);
        checkOutput("hitHits",   32'(hitA),  32'd8);
        checkOutput("hitAddr",   32'(addrA), 32'd1031);
        checkOutput("hitBusy",   32'(busyA), 32'd0);

        // Restart from DONE, then a go pulse mid-run must change nothing.
        $display("[TB] go restart and mid-run go");
        expAddr = 15'd1024;
        pulseGo();
        checkOutput("reAcc",   32'(accA),   32'd0);
        checkOutput("reHit",   32'(hitA),   32'd0);
        checkOutput("reAddr",  32'(addrA),  32'd1024);
        checkOutput("reStart", 32'(startA), 32'd1);
        checkOutput("reDone",  32'(doneA),  32'd0);
        repeat (6) applyStimulus();
        pulseGo();
        checkOutput("midAddr", 32'(addrA), 32'd1025);
        runSweep(100, used);
        checkOutput("midCycles", 32'(used), 32'd25);
        checkOutput("midAcc",    32'(accA), 32'd8);

        // Reset while waiting on the access at 1030.
        $display("[TB] reset mid-sweep");
        expAddr = 15'd1024;
        pulseGo();
        repeat (26) applyStimulus();
        checkOutput("preRstAddr", 32'(addrA), 32'd1030);
        checkOutput("preRstAcc",  32'(accA),  32'd7);
        checkOutput("preRstBusy", 32'(busyA), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 32'(busyA),  32'd0);
        checkOutput("midRstAddr", 32'(addrA),  32'd1024);
        checkOutput("midRstAcc",  32'(accA),   32'd0);
        checkOutput("midRstHit",  32'(hitA),   32'd0);
        checkOutput("midRstStrt", 32'(startA), 32'd0);
        checkOutput("midRstDone", 32'(doneA),  32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        remaining = 0;
        ready     = 1'b1;
        hm_bar    = 1'b1;
        applyStimulus();
        checkOutput("postRstStrt", 32'(startA), 32'd0);
        checkOutput("postRstBusy", 32'(busyA),  32'd0);

        // Miss on the first word of each 4-word block over 1024..1039.
        $display("[TB] miss-then-hit blocks");
        sel = 1; expAddr = 15'd1024; expStride = 1; missMode = 1'b1;
        pulseGo();
        runSweep(200, used);
        checkOutput("mixCycles", 32'(used),  32'd68);
        checkOutput("mixAcc",    32'(accB),  32'd16);
        checkOutput("mixHits",   32'(hitB),  32'd12);
        checkOutput("mixAddr",   32'(addrB), 32'd1039);
        missMode = 1'b0;

        // Stride 3 over 0..7 issues 0,3,6 only.
        $display("[TB] stride overshoot");
        sel = 2; expAddr = 15'd0; expStride = 3;
        pulseGo();
        runSweep(100, used);
        checkOutput("strCycles", 32'(used),  32'd12);
        checkOutput("strAcc",    32'(accC),  32'd3);
        checkOutput("strAddr",   32'(addrC), 32'd6);

        // 4-bit bus: 9,11,13,15 then 17 would wrap, so DONE; 2-bit counters saturate at 3.
        $display("[TB] no-wrap and saturation");
        sel = 3; expAddr = 15'd9; expStride = 2;
        pulseGo();
        runSweep(100, used);
        checkOutput("satCycles", 32'(used),  32'd16);
        checkOutput("satAcc",    32'(accD),  32'd3);
        checkOutput("satHits",   32'(hitD),  32'd3);
        checkOutput("satAddr",   32'(addrD), 32'd15);

`ifdef ACCESS_TIMEOUT_EN
        // Controller never returns ready after accepting: watchdog fires after 15 WAIT cycles.
        $display("[TB] access timeout");
        sel = 0; expAddr = 15'd1024; expStride = 1;
        pulseGo();
        checkOutput("toClear0", 32'(timeoutA), 32'd0);
        stuck = 1'b1;
        applyStimulus();
        repeat (15) applyStimulus();
        checkOutput("toEarly",   32'(doneA),    32'd0);
        applyStimulus();
        checkOutput("toDone",    32'(doneA),    32'd1);
        checkOutput("toFlag",    32'(timeoutA), 32'd1);
        checkOutput("toAcc",     32'(accA),     32'd1);
        stuck     = 1'b0;
        remaining = 0;
        ready     = 1'b1;
        expAddr   = 15'd1024;
        pulseGo();
        checkOutput("toCleared", 32'(timeoutA), 32'd0);
        checkOutput("toReAcc",   32'(accA),     32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cache_access_sequencer.md
Name: cache_access_sequencer

Overview:
- Processor-side initiator for the cache controller handshake (start / address / ready / hm_bar).
- Sweeps a programmed address range one access at a time and holds each address stable for the whole cache transaction.
- Samples the hit/miss indication for every access and accumulates access and hit counts, which are used for hit-rate reporting.
- Sits between the top-level run control and the cache datapath/controller pair.

Parameters:
- ADDR_W, 15, address width. Matches the cache address bus.
- START_ADDR, 1024, first address issued.
- END_ADDR, 9215, last address allowed to be issued.
- STRIDE, 1, address increment between accesses. Must be ≥1.
- CNT_W, 14, width of the access and hit counters.
- TIMEOUT_CYCLES, 15, WAIT-state cycle limit. Used only under ACCESS_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  run request, level-sampled.
- ready  in  1  controller Ready: high when the controller is idle and can accept start.
- hm_bar  in  1  cache HMbar: 1 = hit, 0 = miss.
- start  out  1  access request to the controller.
- address  out  ADDR_W  access address.
- busy  out  1  high from sweep start until DONE.
- done  out  1  high in DONE.
- access_count  out  CNT_W  accesses completed.
- hit_count  out  CNT_W  hits recorded.
- timeout  out  1  watchdog flag. Exists only with ACCESS_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - start=0, busy=0, done=0, timeout=0.
  - address=START_ADDR.
  - Both counters = 0.
  - Asserting reset mid-transaction aborts the sweep immediately. No partial count is kept.
- FSM states: IDLE, ISSUE, SAMPLE, WAIT, DONE. All outputs are registered except start, which is decoded from state.
- IDLE:
  - When go=1: clear counters, set address=START_ADDR, go to ISSUE.
  - busy rises in the same edge.
- ISSUE:
  - start=1.
  - If ready=1 at the edge, go to SAMPLE. The controller accepts on that same edge.
  - If ready=0, hold ISSUE with start kept high.
- SAMPLE:
  - start=0. The controller is in its read state.
  - At the edge: access_count += 1, hit_count += hm_bar, go to WAIT.
- WAIT:
  - start=0, address held.
  - When ready=1: the transaction is complete.
  - If address + STRIDE (computed in ADDR_W+1 bits) > END_ADDR, go to DONE. Otherwise address += STRIDE and go to ISSUE.
- DONE:
  - done=1, busy=0, counters frozen.
  - If go=1, restart exactly as from IDLE: clear counters, load START_ADDR, go to ISSUE.
- Address stability: address changes only on the WAIT→ISSUE or IDLE/DONE→ISSUE edge, never while the controller is mid-transaction.
- Per-access cost:
  - Hit: 4 cycles (ISSUE, SAMPLE, WAIT×1, plus the controller's CheckAddress cycle absorbed in WAIT).
  - Miss: 5 cycles.
- go is ignored while busy.
- Counters saturate at all-ones; they never wrap.
- START_ADDR > END_ADDR: one access at START_ADDR is issued, then DONE.
- STRIDE overshoot: a sweep never issues any address above END_ADDR and never wraps the address bus.

Optional Feature:
- Macro: ACCESS_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs in WAIT.
  - If ready stays 0 for TIMEOUT_CYCLES consecutive WAIT cycles, set timeout=1 and go to DONE. The current access remains counted.
  - timeout clears on the next go restart or on reset.
- Undefined: no counter, no timeout port, and WAIT waits indefinitely.

Decomposition:
- Shared package cache_pkg: ADDR_W, the state enum for the FSM, the default START_ADDR/END_ADDR values, and the hit/miss encoding constant (HIT=1'b1).
- Natural sub-module: sat_counter, a parameterised saturating up-counter with clear and enable, instantiated for access_count and hit_count.

Test Plan:
- Reset mid-sweep: pulse rst_n low for 1 cycle while in WAIT at address 1030 → all outputs return to reset values immediately, address=1024, counters=0.
- All-hit run with START=1024, END=1031, cache model always hit → 8 accesses, access_count=8, hit_count=8, done after 32 cycles, address sequence 1024..1031 each held across its transaction.
- Miss-then-hit per block, 4-word blocks over 1024..1039 → access_count=16, hit_count=12, each miss takes 5 cycles.
- Stride overshoot, STRIDE=3, START=0, END=7 → addresses 0,3,6 only, then DONE with access_count=3.
- go pulsed while busy, then again in DONE → the mid-run pulse has no effect; the DONE pulse clears counters and reissues START_ADDR on the next edge.
- ACCESS_TIMEOUT_EN defined, cache model holds ready=0 after accepting start → timeout=1 and done=1 exactly 15 WAIT cycles later, access_count=1.
